// File: rtl/mult_div_seq.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on operand magnitudes, sign fix-up at the end.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Funct,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MRUN = 3'd1;
    localparam logic [2:0] DRUN = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    logic             signed_op;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign signed_op = ~Funct[0];
    assign mag_a     = (signed_op && OpA[WIDTH-1]) ? -OpA : OpA;
    assign mag_b     = (signed_op && OpB[WIDTH-1]) ? -OpB : OpB;

    // Multiply keeps {acc, q_reg} as the shifting product; divide keeps {acc, q_reg} as
    // partial remainder and dividend/quotient, with m_reg holding the multiplicand/divisor.
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               fits;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign add_sum  = {1'b0, acc} + (q_reg[0] ? {1'b0, m_reg} : '0);
    assign shifted  = {acc, q_reg[WIDTH-1]};
    assign trial    = shifted - {1'b0, m_reg};
    assign fits     = (shifted >= {1'b0, m_reg});
    assign prod     = {acc, q_reg};
    assign prod_fix = neg_q ? -prod : prod;
    assign quot_fix = neg_q ? -q_reg : q_reg;
    assign rem_fix  = neg_r ? -acc : acc;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            m_reg    <= '0;
            q_reg    <= '0;
            acc      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        is_div   <= Funct[1];
                        neg_q    <= signed_op & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        neg_r    <= signed_op & Funct[1] & OpA[WIDTH-1];
                        div_zero <= Funct[1] & (OpB == '0);
                        m_reg    <= Funct[1] ? mag_b : mag_a;
                        q_reg    <= Funct[1] ? mag_a : mag_b;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= Funct[1] ? DRUN : MRUN;
                    end else begin
                        if (HiWrite) hi_r <= WrData;
                        if (LoWrite) lo_r <= WrData;
                    end
                end
                MRUN: begin
                    acc   <= add_sum[WIDTH:1];
                    q_reg <= {add_sum[0], q_reg[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) state <= FIX;
                end
                DRUN: begin
                    acc   <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    q_reg <= {q_reg[WIDTH-2:0], fits};
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end else if (!div_zero) begin
                        hi_r <= rem_fix;
                        lo_r <= quot_fix;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (HiWrite) hi_r <= WrData;
                    if (LoWrite) lo_r <= WrData;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy    = (state == MRUN) || (state == DRUN) || (state == FIX);
    assign Done    = (state == DONE);
    assign DivZero = (state == DONE) && div_zero;
    assign Hi      = hi_r;
    assign Lo      = lo_r;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: directed cases plus randomized operations
// compared against a 64-bit arithmetic reference model.
module tb_mult_div_seq;
    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Start = 1'b0;
    logic [1:0]   Funct = 2'b00;
    logic [W-1:0] OpA = '0;
    logic [W-1:0] OpB = '0;
    logic         HiWrite = 1'b0;
    logic         LoWrite = 1'b0;
    logic [W-1:0] WrData = '0;
    logic         Busy;
    logic         Done;
    logic         DivZero;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;

    int           checks = 0;
    int           fails = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    always #5 Clk = ~Clk;

    mult_div_seq #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Funct(Funct),
        .OpA(OpA), .OpB(OpB), .HiWrite(HiWrite), .LoWrite(LoWrite),
        .WrData(WrData), .Busy(Busy), .Done(Done), .DivZero(DivZero),
        .Hi(Hi), .Lo(Lo)
    );

    // Reference: MIPS HI/LO semantics via plain 64-bit arithmetic (truncating division).
    task automatic model(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         inout logic [W-1:0] h, inout logic [W-1:0] l, output bit dz);
        longint          sa, sb, sq, sr;
        logic [63:0]     t;
        logic [63:0]     tr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (f)
            2'b00: begin t = sa * sb; h = t[63:32]; l = t[31:0]; end
            2'b01: begin t = {32'd0, a} * {32'd0, b}; h = t[63:32]; l = t[31:0]; end
            2'b10: begin
                if (b == '0) dz = 1'b1;
                else begin
                    sq = sa / sb; sr = sa % sb;
                    t = sq; tr = sr;
                    l = t[31:0]; h = tr[31:0];
                end
            end
            default: begin
                if (b == '0) dz = 1'b1;
                else begin l = a / b; h = a % b; end
            end
        endcase
    endtask

    // Launch one operation, scramble inputs after capture, wait (bounded) for Done.
    // Returns at the sampling point of the DONE cycle.
    task automatic do_op(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit lo_wr, input bit hi_wr_busy,
                         output int busy_n, output bit timed_out);
        @(negedge Clk);
        Start = 1'b1; Funct = f; OpA = a; OpB = b; LoWrite = lo_wr; WrData = $urandom;
        @(negedge Clk);
        Start = 1'b0; LoWrite = 1'b0;
        Funct = 2'($urandom); OpA = $urandom; OpB = $urandom;
        HiWrite = hi_wr_busy;
        if (hi_wr_busy) WrData = 32'h0000AAAA;
        busy_n = 0;
        while (Busy && busy_n < 100) begin
            busy_n++;
            @(negedge Clk);
        end
        HiWrite = 1'b0;
        timed_out = (Done !== 1'b1);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if (Hi !== '0) begin fails++; $display("FAIL reset_hi got=%h exp=0", Hi); end
        checks++; if (Lo !== '0) begin fails++; $display("FAIL reset_lo got=%h exp=0", Lo); end
        checks++; if ({Busy, Done, DivZero} !== 3'b000) begin
            fails++; $display("FAIL reset_flags got=%b exp=000", {Busy, Done, DivZero});
        end
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_multu_max();
        int n; bit to, dz;
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, n, to);
        model(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, exp_hi, exp_lo, dz);
        checks++; if (to) begin fails++; $display("FAIL multu_done got=%b exp=1", Done); end
        checks++; if (n != 33) begin fails++; $display("FAIL busy_len got=%0d exp=33", n); end
        checks++; if (Hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_hi got=%h exp=fffffffe", Hi); end
        checks++; if (Lo !== 32'h00000001) begin fails++; $display("FAIL multu_lo got=%h exp=00000001", Lo); end
        checks++; if (DivZero !== 1'b0) begin fails++; $display("FAIL multu_divzero got=%b exp=0", DivZero); end
        @(negedge Clk);
        checks++; if (Done !== 1'b0) begin fails++; $display("FAIL done_width got=%b exp=0", Done); end
    endtask

    task automatic test_mult_signed();
        int n; bit to, dz;
        do_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, n, to);
        model(2'b00, 32'hFFFFFFFD, 32'd7, exp_hi, exp_lo, dz);
        checks++; if (to) begin fails++; $display("FAIL mult_neg_done got=%b exp=1", Done); end
        checks++; if ({Hi, Lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            fails++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_ffffffeb", Hi, Lo);
        end
        do_op(2'b00, 32'h80000000, 32'h80000000, 1'b0, 1'b0, n, to);
        model(2'b00, 32'h80000000, 32'h80000000, exp_hi, exp_lo, dz);
        checks++; if (to) begin fails++; $display("FAIL mult_min_done got=%b exp=1", Done); end
        checks++; if ({Hi, Lo} !== 64'h40000000_00000000) begin
            fails++; $display("FAIL mult_min got=%h_%h exp=40000000_00000000", Hi, Lo);
        end
    endtask

    task automatic test_div();
        int n; bit to, dz;
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic [1:0]   tf [3];
        logic [63:0]  te [3];
        ta = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
        tb = '{32'd2, 32'd2, 32'hFFFFFFFF};
        tf = '{2'b10, 2'b11, 2'b10};
        te = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_00000003, 64'h00000000_80000000};
        for (int i = 0; i < 3; i++) begin
            do_op(tf[i], ta[i], tb[i], 1'b0, 1'b0, n, to);
            model(tf[i], ta[i], tb[i], exp_hi, exp_lo, dz);
            checks++; if (to) begin fails++; $display("FAIL div%0d_done got=%b exp=1", i, Done); end
            checks++; if ({Hi, Lo} !== te[i]) begin
                fails++; $display("FAIL div%0d got=%h_%h exp=%h", i, Hi, Lo, te[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int n; bit to, dz;
        @(negedge Clk); HiWrite = 1'b1; WrData = 32'h1234;
        @(negedge Clk); HiWrite = 1'b0; LoWrite = 1'b1; WrData = 32'h5678;
        @(negedge Clk); LoWrite = 1'b0;
        exp_hi = 32'h1234; exp_lo = 32'h5678;
        checks++; if ({Hi, Lo} !== {exp_hi, exp_lo}) begin
            fails++; $display("FAIL mthi_mtlo got=%h_%h exp=%h_%h", Hi, Lo, exp_hi, exp_lo);
        end
        for (int i = 0; i < 2; i++) begin
            do_op(i == 0 ? 2'b11 : 2'b10, $urandom, '0, 1'b0, 1'b0, n, to);
            checks++; if (to || n != 33) begin
                fails++; $display("FAIL divz%0d_timing got busy=%0d done=%b exp busy=33 done=1", i, n, Done);
            end
            checks++; if (DivZero !== 1'b1) begin fails++; $display("FAIL divz%0d_flag got=%b exp=1", i, DivZero); end
            checks++; if ({Hi, Lo} !== {exp_hi, exp_lo}) begin
                fails++; $display("FAIL divz%0d_hold got=%h_%h exp=%h_%h", i, Hi, Lo, exp_hi, exp_lo);
            end
            @(negedge Clk);
            checks++; if ({Done, DivZero} !== 2'b00) begin
                fails++; $display("FAIL divz%0d_pulse got=%b exp=00", i, {Done, DivZero});
            end
        end
    endtask

    task automatic test_contention();
        int n; bit to, dz;
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom;
        do_op(2'b01, a, b, 1'b0, 1'b1, n, to);
        model(2'b01, a, b, exp_hi, exp_lo, dz);
        checks++; if (to) begin fails++; $display("FAIL busy_write_done got=%b exp=1", Done); end
        checks++; if (Hi !== exp_hi) begin fails++; $display("FAIL busy_write_hi got=%h exp=%h", Hi, exp_hi); end
        a = $urandom; b = $urandom_range(1, 1000);
        do_op(2'b11, a, b, 1'b1, 1'b0, n, to);
        model(2'b11, a, b, exp_hi, exp_lo, dz);
        checks++; if (to) begin fails++; $display("FAIL start_lowrite_done got=%b exp=1", Done); end
        checks++; if ({Hi, Lo} !== {exp_hi, exp_lo}) begin
            fails++; $display("FAIL start_lowrite got=%h_%h exp=%h_%h", Hi, Lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_start_held();
        logic [W-1:0] a, b;
        bit dz, exp_busy, exp_done;
        int pos;
        int bad;
        a = $urandom; b = $urandom;
        model(2'b01, a, b, exp_hi, exp_lo, dz);
        bad = 0;
        @(negedge Clk);
        Start = 1'b1; Funct = 2'b01; OpA = a; OpB = b;
        for (int k = 1; k <= 70; k++) begin
            @(negedge Clk);
            pos = (k - 1) % 35;
            exp_busy = (pos < 33);
            exp_done = (pos == 33);
            checks++; if ({Busy, Done} !== {exp_busy, exp_done}) begin
                fails++; bad++;
                if (bad < 5) $display("FAIL start_held k=%0d got busy/done=%b exp=%b", k, {Busy, Done}, {exp_busy, exp_done});
            end
            if (exp_done) begin
                checks++; if ({Hi, Lo} !== {exp_hi, exp_lo}) begin
                    fails++; $display("FAIL start_held_result got=%h_%h exp=%h_%h", Hi, Lo, exp_hi, exp_lo);
                end
            end
        end
        Start = 1'b0;
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin fails++; $display("FAIL start_released got=%b exp=0", Busy); end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h80000000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int n; bit to, dz;
        logic [1:0]   f;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            f = 2'($urandom); a = pick_operand(); b = pick_operand();
            do_op(f, a, b, 1'b0, 1'b0, n, to);
            model(f, a, b, exp_hi, exp_lo, dz);
            checks++; if (to || n != 33) begin
                fails++; $display("FAIL rand%0d_timing got busy=%0d done=%b exp busy=33 done=1", i, n, Done);
            end
            checks++; if ({Hi, Lo, DivZero} !== {exp_hi, exp_lo, dz}) begin
                fails++; $display("FAIL rand%0d f=%b a=%h b=%h got=%h_%h dz=%b exp=%h_%h dz=%b",
                                  i, f, a, b, Hi, Lo, DivZero, exp_hi, exp_lo, dz);
            end
        end
    endtask

    task automatic test_reset_midop();
        int bad;
        @(negedge Clk);
        Start = 1'b1; Funct = 2'b00; OpA = $urandom; OpB = $urandom;
        @(negedge Clk);
        Start = 1'b0;
        repeat (10) @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++; if ({Busy, Hi, Lo} !== {1'b0, 64'd0}) begin
            fails++; $display("FAIL reset_midop got busy=%b hi=%h lo=%h exp busy=0 hi=0 lo=0", Busy, Hi, Lo);
        end
        @(negedge Clk);
        Reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (Done !== 1'b0 || Busy !== 1'b0 || Hi !== '0 || Lo !== '0) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL reset_midop_after got=%0d bad cycles exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div();
        test_div_zero();
        test_contention();
        test_start_held();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
Iterative multiply/divide sequencer for the multicycle MIPS core, owning the HI/LO register pair. The main control unit issues MULT/MULTU/DIV/DIVU through a Start/Busy/Done handshake and stays in a wait state while Busy is high. The block runs one shift-add or shift-subtract step per cycle on internal A/B/accumulator registers. It also services MTHI/MTLO writes, and it exposes Hi/Lo continuously for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; Hi and Lo are each WIDTH bits; iteration count equals WIDTH.

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low
Start  in  1  launch operation; sampled only in IDLE
Funct  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with Start
OpA  in  WIDTH  multiplicand / dividend (rs)
OpB  in  WIDTH  multiplier / divisor (rt)
HiWrite  in  1  MTHI strobe; load Hi from WrData
LoWrite  in  1  MTLO strobe; load Lo from WrData
WrData  in  WIDTH  MTHI/MTLO data
Busy  out  1  operation in progress; control unit must stall
Done  out  1  one-cycle pulse; Hi/Lo hold the new result in this cycle
DivZero  out  1  one-cycle pulse with Done when divisor was zero
Hi  out  WIDTH  HI register
Lo  out  WIDTH  LO register

Behaviour:
- Reset (async, Reset=0): state IDLE; Hi=0, Lo=0; Busy=0, Done=0, DivZero=0; internal counter and operand registers cleared. Applies mid-operation: the operation is abandoned and no partial result reaches Hi/Lo.
- States:
  - IDLE: Start=1 -> capture Funct, OpA, OpB. Go to MRUN (Funct[1]=0) or DRUN (Funct[1]=1).
  - MRUN / DRUN: one iteration per cycle, counter 0..WIDTH-1. After the WIDTH-th iteration go to FIX.
  - FIX: sign correction, then Hi/Lo load; next state DONE.
  - DONE: one cycle, then IDLE.
- Busy=1 in MRUN, DRUN and FIX (WIDTH+1 cycles). Busy=0 in IDLE and DONE.
- Timing:
  - Start is sampled at edge E0.
  - Hi/Lo are updated at edge E0+WIDTH+1.
  - Done=1 for the cycle following that edge (the DONE state).
  - Start may be asserted again in the cycle after Done.
- Signed ops: operands are converted to magnitudes at capture. Unsigned iteration runs on the magnitudes. FIX negates the result:
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend (truncate toward zero).
- Results:
  - MULT/MULTU: {Hi,Lo} = full 2*WIDTH product.
  - DIV/DIVU: Lo = quotient, Hi = remainder.
- DIV of -2^(WIDTH-1) by -1: Lo=0x80000000, Hi=0 (natural wrap, no flag).
- Divide by zero (OpB=0 at capture, DIV or DIVU): full latency still elapses. Hi/Lo are NOT written. DivZero pulses together with Done.
- HiWrite/LoWrite:
  - Honoured only in IDLE and DONE; Hi/Lo load on the next edge.
  - Ignored while Busy=1.
  - Both asserted together: both registers load WrData.
  - Start and HiWrite/LoWrite in the same IDLE cycle: Start wins, the writes are dropped.
- Start while Busy=1 or in DONE is ignored (no queueing).
- Funct/OpA/OpB changes after capture have no effect on the running operation.
- Done and DivZero are never high outside the DONE state.

Test Plan:
- Reset mid-op: MULT started, Reset pulled low at iteration 10 -> Hi=Lo=0, Busy=0 immediately, no Done pulse afterwards.
- MULTU with OpA=0xFFFFFFFF, OpB=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001 with Done. Also check Busy high exactly 33 cycles and Done exactly one cycle.
- MULT with OpA=-3 (0xFFFFFFFD), OpB=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then immediately MULT with 0x80000000 * 0x80000000 -> Hi=0x40000000, Lo=0.
- DIV with OpA=-7, OpB=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU with 7/2 -> Lo=3, Hi=1. DIV with 0x80000000/-1 -> Lo=0x80000000, Hi=0.
- Divide by zero: preload Hi=0x1234, Lo=0x5678 via MTHI/MTLO. Then DIVU with OpB=0 -> after 33 cycles Done=1, DivZero=1, Hi/Lo unchanged.
- Contention: HiWrite with WrData=0xAAAA during Busy -> ignored. Start+LoWrite in the same IDLE cycle -> operation runs, Lo ends with the result, not WrData. Start held high throughout -> a new op launches only after DONE.
